vga_object_engine: RTL and testbench
====================================

Name: vga_object_engine

Overview:
- Parametrised successor to the fixed-rectangle pixel colouriser that sits between the VGA_controller coordinate outputs and its iRed/iGreen/iBlue inputs.
- Draws NUM_OBJ runtime-programmable rectangles with fixed index priority, where object 0 is on top.
- Moves each rectangle once per frame using a signed per-object velocity, and reflects it off the screen edges.
- Reports per-object overlap (collision) flags for the previous frame.

Parameters:
- NUM_OBJ, 4, number of rectangles (1..16).
- COORD_W, 10, width of pixel coordinates and object geometry.
- H_RES, 640, visible columns.
- V_RES, 480, visible rows.
- VEL_W, 4, width of the signed per-axis velocity in pixels/frame.

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  pixel strobe (every other clock); pixel pipeline advances only when 1.
- iCoord_X  in  COORD_W  current pixel column from VGA_controller.
- iCoord_Y  in  COORD_W  current pixel row from VGA_controller.
- frame_tick  in  1  single-cycle pulse once per frame during vertical blanking.
- cfg_we  in  1  configuration write strobe.
- cfg_obj  in  $clog2(NUM_OBJ) (min 1)  target object index.
- cfg_field  in  3  0=X, 1=Y, 2=W, 3=H, 4=colour, 5=motion, 6=background (cfg_obj ignored), 7=reserved.
- cfg_data  in  24  write data. X/Y/W/H use [COORD_W-1:0]. Colour is {R,G,B}. Motion is {move_en[2*VEL_W], dy[2*VEL_W-1:VEL_W], dx[VEL_W-1:0]}.
- busy  out  1  motion update in progress; config writes are ignored while 1.
- oRed  out  8  registered red.
- oGreen  out  8  registered green.
- oBlue  out  8  registered blue.
- collision  out  NUM_OBJ  bit i set if object i overlapped any other object on a visible pixel during the previous frame.

Behaviour:
- Reset: all X, Y, W, H, colour, dx, dy and move_en are cleared to 0, and the background is cleared to 0. oRed, oGreen, oBlue = 0; busy = 0; collision = 0; FSM = IDLE.
- Hit test: object i hits when X_i <= iCoord_X < X_i+W_i and Y_i <= iCoord_Y < Y_i+H_i. Sums are evaluated at COORD_W+1 bits with no wrap. W=0 or H=0 never hits.
- Pixel pipeline: on a clock edge with enable=1, the output registers load the colour of the lowest-index hitting object, or the background if no object hits. A coordinate that is valid when enable=1 therefore appears on oRGB after that edge (1 enable-qualified edge of latency). With enable=0 the outputs hold.
- Pixels with iCoord_X >= H_RES or iCoord_Y >= V_RES output 0 and do not update collision state.
- Collision accumulation: on each enable edge with a visible pixel, if 2 or more objects hit, every hitting object's bit in an internal accumulator is set.
- Collision publish: on frame_tick, the accumulator is copied to collision and the accumulator is cleared in the same cycle. A hit that coincides with that edge goes into the new, cleared accumulator.
- Config writes: accepted only when busy=0, taking effect on the edge where cfg_we=1. cfg_field 7 is a no-op.
- FSM states: IDLE and UPDATE.
  - IDLE to UPDATE on frame_tick; the index counter is set to 0 and busy=1 from the next cycle.
  - In UPDATE, one object is processed per clock, independent of enable, and the index increments.
  - UPDATE to IDLE after index NUM_OBJ-1; busy is low in the following cycle.
  - A frame_tick while in UPDATE is ignored.
- Motion per object, only when move_en=1; same rules for Y using dy, H and V_RES:
  - Arithmetic is signed at COORD_W+2 bits: nx = X + sign-extended dx.
  - If nx < 0: X=0 and dx=-dx.
  - Else if nx+W > H_RES: X=H_RES-W (0 if W > H_RES) and dx=-dx.
  - Otherwise X=nx.
  - dx = -2^(VEL_W-1) negates to +(2^(VEL_W-1)-1) (saturating).
  - dx=0 leaves the object stationary.
- Mid-frame geometry changes take effect from the next enable edge, so tearing is allowed.
- Reset mid-UPDATE returns to IDLE immediately with all state cleared.

Test Plan:
- Reset, then obj0 = X=300, Y=220, W=H=40, colour FFFFFF; background 000010 -> coord (300,220) gives FFFFFF after 1 enable edge; (340,220) and (299,259) give 000010; (50,500) gives 000000.
- obj0 and obj1 overlap at (305,225), obj1 colour FF0000 -> output FFFFFF. After frame_tick, collision = 0011; a frame with no overlap, then frame_tick -> collision = 0000.
- obj2 X=630, W=8, dx=+5, move_en=1; frame_tick -> busy high for NUM_OBJ cycles; X=632 and dx=-5. Next tick -> X=627.
- obj3 Y=2, dy=-8 (dy=1000b, VEL_W=4) -> after tick, Y=0 and dy=+7.
- cfg_we to X while busy=1 -> X unchanged; the same write after busy falls -> applied.
- resetn pulsed low mid-UPDATE -> busy, oRGB and collision are 0 asynchronously; all objects are disabled and output only background 0.

Source files
------------

// File: rtl/vga_object_engine.sv
// Pixel colouriser drawing NUM_OBJ programmable rectangles with index priority,
// per-frame edge-reflecting motion and previous-frame overlap flags.
module vga_object_engine #(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned VEL_W   = 4,
    localparam int unsigned IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic [COORD_W-1:0] iCoord_X,
    input  logic [COORD_W-1:0] iCoord_Y,
    input  logic               frame_tick,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_obj,
    input  logic [2:0]         cfg_field,
    input  logic [23:0]        cfg_data,
    output logic               busy,
    output logic [7:0]         oRed,
    output logic [7:0]         oGreen,
    output logic [7:0]         oBlue,
    output logic [NUM_OBJ-1:0] collision
);

    localparam int unsigned SW   = COORD_W + 2;
    localparam int unsigned ST_W = VEL_W + COORD_W;
    localparam logic [COORD_W:0] H_LIM   = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM   = (COORD_W+1)'(V_RES);
    localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W-1:0] VEL_MAX = ~VEL_MIN;

    typedef enum logic {S_IDLE, S_UPDATE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;

    logic [COORD_W-1:0] obj_x   [NUM_OBJ];
    logic [COORD_W-1:0] obj_y   [NUM_OBJ];
    logic [COORD_W-1:0] obj_w   [NUM_OBJ];
    logic [COORD_W-1:0] obj_h   [NUM_OBJ];
    logic [23:0]        obj_col [NUM_OBJ];
    logic [VEL_W-1:0]   obj_dx  [NUM_OBJ];
    logic [VEL_W-1:0]   obj_dy  [NUM_OBJ];
    logic [NUM_OBJ-1:0] obj_mv;
    logic [23:0]        bg_col;

    logic [ST_W-1:0]    step_x, step_y;
    logic [NUM_OBJ-1:0] hit, acc_hit, coll_acc;
    logic               visible, multi, any_hit;
    logic [23:0]        pix_col;

    // One axis of motion: returns {new_velocity, new_position}.
    function automatic logic [ST_W-1:0] axis_step(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] size,
        input logic [VEL_W-1:0]   vel,
        input logic [COORD_W:0]   lim
    );
        logic signed [SW-1:0] np;
        logic [VEL_W-1:0]     nv;
        np = $signed({2'b00, pos}) + $signed({{(SW-VEL_W){vel[VEL_W-1]}}, vel});
        nv = (vel == VEL_MIN) ? VEL_MAX : VEL_W'(~vel + VEL_W'(1));
        if (np[SW-1]) begin
            axis_step = {nv, COORD_W'(0)};
        end else if ($unsigned(np) + SW'(size) > SW'(lim)) begin
            axis_step = {nv, ({1'b0, size} > lim) ? COORD_W'(0)
                                                  : COORD_W'(lim - {1'b0, size})};
        end else begin
            axis_step = {vel, np[COORD_W-1:0]};
        end
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= (state_nxt == S_UPDATE);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    state_nxt = S_UPDATE;
                    idx_nxt   = '0;
                end
            end
            S_UPDATE: begin
                if (idx == IDX_W'(NUM_OBJ - 1)) state_nxt = S_IDLE;
                else                             idx_nxt   = idx + IDX_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        step_x = axis_step(obj_x[idx], obj_w[idx], obj_dx[idx], H_LIM);
        step_y = axis_step(obj_y[idx], obj_h[idx], obj_dy[idx], V_LIM);
    end

    // Object table: motion owns it while busy, otherwise config writes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                obj_x[i]   <= '0;
                obj_y[i]   <= '0;
                obj_w[i]   <= '0;
                obj_h[i]   <= '0;
                obj_col[i] <= '0;
                obj_dx[i]  <= '0;
                obj_dy[i]  <= '0;
            end
            obj_mv <= '0;
            bg_col <= '0;
        end else if (busy) begin
            if (obj_mv[idx]) begin
                obj_x[idx]  <= step_x[COORD_W-1:0];
                obj_dx[idx] <= step_x[ST_W-1:COORD_W];
                obj_y[idx]  <= step_y[COORD_W-1:0];
                obj_dy[idx] <= step_y[ST_W-1:COORD_W];
            end
        end else if (cfg_we) begin
            case (cfg_field)
                3'd0: obj_x[cfg_obj]   <= cfg_data[COORD_W-1:0];
                3'd1: obj_y[cfg_obj]   <= cfg_data[COORD_W-1:0];
                3'd2: obj_w[cfg_obj]   <= cfg_data[COORD_W-1:0];
                3'd3: obj_h[cfg_obj]   <= cfg_data[COORD_W-1:0];
                3'd4: obj_col[cfg_obj] <= cfg_data;
                3'd5: begin
                    obj_dx[cfg_obj] <= cfg_data[VEL_W-1:0];
                    obj_dy[cfg_obj] <= cfg_data[2*VEL_W-1:VEL_W];
                    obj_mv[cfg_obj] <= cfg_data[2*VEL_W];
                end
                3'd6: bg_col <= cfg_data;
                default: ;
            endcase
        end
    end

    // Hit test, priority colour select and overlap detect for the current pixel.
    always_comb begin
        visible = ({1'b0, iCoord_X} < H_LIM) && ({1'b0, iCoord_Y} < V_LIM);
        hit     = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit[i] = (iCoord_X >= obj_x[i])
                  && ({1'b0, iCoord_X} < ({1'b0, obj_x[i]} + {1'b0, obj_w[i]}))
                  && (iCoord_Y >= obj_y[i])
                  && ({1'b0, iCoord_Y} < ({1'b0, obj_y[i]} + {1'b0, obj_h[i]}));
        end
        pix_col = bg_col;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) pix_col = obj_col[i];
        end
        any_hit = 1'b0;
        multi   = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (hit[i]) begin
                multi   = multi | any_hit;
                any_hit = 1'b1;
            end
        end
        acc_hit = (enable && visible && multi) ? hit : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            {oRed, oGreen, oBlue} <= 24'h0;
        end else if (enable) begin
            {oRed, oGreen, oBlue} <= visible ? pix_col : 24'h0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            collision <= '0;
            coll_acc  <= '0;
        end else if (frame_tick) begin
            collision <= coll_acc;
            coll_acc  <= acc_hit;
        end else begin
            coll_acc  <= coll_acc | acc_hit;
        end
    end

endmodule

// File: tb/tb_vga_object_engine.sv
// Directed bench for vga_object_engine: pixel colours go through a scoreboard queue,
// motion is observed through where each rectangle is drawn.
module tb_vga_object_engine;

    logic        clock = 1'b0;
    logic        resetn, enable, frame_tick, cfg_we;
    logic [9:0]  iCoord_X, iCoord_Y;
    logic [1:0]  cfg_obj;
    logic [2:0]  cfg_field;
    logic [23:0] cfg_data;
    logic        busy;
    logic [7:0]  oRed, oGreen, oBlue;
    logic [3:0]  collision;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] sb[$];
    int          nbusy;

    vga_object_engine dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_obj(cfg_obj), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .busy(busy), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .collision(collision)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int obj, input int field, input logic [23:0] data);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_obj   = 2'(obj);
        cfg_field = 3'(field);
        cfg_data  = data;
        @(posedge clock);
        #1 cfg_we = 1'b0;
    endtask

    task automatic set_obj(input int obj, input int x, input int y, input int w, input int h,
                           input logic [23:0] col);
        cfg(obj, 0, 24'(x));
        cfg(obj, 1, 24'(y));
        cfg(obj, 2, 24'(w));
        cfg(obj, 3, 24'(h));
        cfg(obj, 4, col);
    endtask

    task automatic pixel(input string tag, input int x, input int y, input logic [23:0] exp);
        @(negedge clock);
        iCoord_X = 10'(x);
        iCoord_Y = 10'(y);
        enable   = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1 enable = 1'b0;
        check(tag, {8'h0, oRed, oGreen, oBlue}, {8'h0, sb.pop_front()});
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && busy; c++) begin
            @(posedge clock);
            #1;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    // Pulse frame_tick and count the cycles busy stays high afterwards.
    task automatic tick(output int n);
        @(negedge clock);
        frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            n++;
            @(posedge clock);
            #1;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0;
        iCoord_X = '0; iCoord_Y = '0; cfg_obj = '0; cfg_field = '0; cfg_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rgb", {8'h0, oRed, oGreen, oBlue}, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_coll", 32'(collision), 32'd0);
        @(negedge clock) resetn = 1'b1;

        // Single rectangle, edges and invisible region
        set_obj(0, 300, 220, 40, 40, 24'hFFFFFF);
        cfg(0, 6, 24'h000010);
        pixel("p_in", 300, 220, 24'hFFFFFF);
        pixel("p_right", 340, 220, 24'h000010);
        pixel("p_bottom", 299, 259, 24'h000010);
        pixel("p_corner", 339, 259, 24'hFFFFFF);
        pixel("p_invis", 50, 500, 24'h000000);
        @(negedge clock);
        iCoord_X = 10'd300; iCoord_Y = 10'd220;
        @(posedge clock);
        #1 check("hold", {8'h0, oRed, oGreen, oBlue}, 32'h0);

        // Priority and collision publish/clear
        set_obj(1, 305, 225, 10, 10, 24'hFF0000);
        pixel("p_prio", 305, 225, 24'hFFFFFF);
        tick(nbusy);
        check("coll_set", 32'(collision), 32'h3);
        pixel("p_solo", 300, 220, 24'hFFFFFF);
        tick(nbusy);
        check("coll_clr", 32'(collision), 32'h0);

        // Right-edge reflection
        set_obj(2, 630, 10, 8, 4, 24'h00FF00);
        cfg(2, 5, 24'h105);
        tick(nbusy);
        check("busy_cycles", 32'(nbusy), 32'd4);
        pixel("x632_in", 632, 10, 24'h00FF00);
        pixel("x632_lo", 631, 10, 24'h000010);
        pixel("x632_hi", 639, 10, 24'h00FF00);
        tick(nbusy);
        pixel("x627_in", 627, 10, 24'h00FF00);
        pixel("x627_lo", 626, 10, 24'h000010);
        pixel("x627_hi", 634, 10, 24'h00FF00);
        pixel("x627_out", 635, 10, 24'h000010);
        cfg(2, 5, 24'h0);

        // Top-edge reflection with saturating velocity negate
        set_obj(3, 100, 2, 4, 4, 24'h0000FF);
        cfg(3, 5, 24'h180);
        tick(nbusy);
        pixel("y0_top", 100, 0, 24'h0000FF);
        pixel("y0_last", 100, 3, 24'h0000FF);
        pixel("y0_below", 100, 4, 24'h000010);
        tick(nbusy);
        pixel("y7_above", 100, 6, 24'h000010);
        pixel("y7_top", 100, 7, 24'h0000FF);
        pixel("y7_last", 103, 10, 24'h0000FF);
        pixel("y7_below", 100, 11, 24'h000010);
        cfg(3, 5, 24'h0);

        // Config write during busy is dropped, accepted afterwards
        @(negedge clock) frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        cfg_we = 1'b1; cfg_obj = 2'd0; cfg_field = 3'd0; cfg_data = 24'd100;
        @(posedge clock);
        #1 cfg_we = 1'b0;
        wait_idle();
        pixel("busy_wr_kept", 300, 220, 24'hFFFFFF);
        pixel("busy_wr_new", 100, 220, 24'h000010);
        cfg(0, 0, 24'd100);
        pixel("idle_wr_new", 100, 220, 24'hFFFFFF);
        pixel("idle_wr_old", 300, 220, 24'h000010);

        // Asynchronous reset in the middle of an update
        cfg(1, 0, 24'd110);
        pixel("p_prio2", 110, 225, 24'hFFFFFF);
        @(negedge clock) frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_coll", 32'(collision), 32'h3);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rgb", {8'h0, oRed, oGreen, oBlue}, 32'h0);
        check("mid_rst_coll", 32'(collision), 32'h0);
        @(negedge clock) resetn = 1'b1;
        pixel("post_rst_o0", 100, 220, 24'h000000);
        pixel("post_rst_o1", 110, 225, 24'h000000);
        pixel("post_rst_o3", 100, 8, 24'h000000);
        check("post_rst_busy", 32'(busy), 32'd0);
        tick(nbusy);
        check("post_rst_coll", 32'(collision), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
